// File: rtl/uart_regfile_rx.sv
`default_nettype none
// ============================================================================
// uart_regfile_rx : UART command-frame decoder driving a flop-based regfile
// Rev 1.0
// ============================================================================
module uart_regfile_rx #(
  parameter int BAUD_DIV    = 104,
  parameter int OVERSAMPLE  = 16,
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 4,
  parameter int PARITY_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_rx,
  input  logic                     i_reply_ready,
  output logic                     o_reply_valid,
  output logic [ADDR_W+DATA_W:0]   o_reply_data,
  output logic                     o_parity_error,
  output logic                     o_frame_error,
  output logic                     o_overrun,
  output logic                     o_busy,
  output logic [2:0]               o_state
);

  localparam int c_PW    = 1 + ADDR_W + DATA_W;
  localparam int c_DEPTH = 2**ADDR_W;
  localparam int c_DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int c_OS_W  = $clog2(OVERSAMPLE);
  localparam int c_BIT_W = $clog2(c_PW + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BAUD_DIV - 1);
  localparam logic [c_OS_W-1:0]  c_OS_MID   = c_OS_W'(OVERSAMPLE/2 - 1);
  localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVERSAMPLE - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_PW);
  localparam logic               c_HAS_PAR  = (PARITY_MODE != 2);
  localparam logic               c_ODD_PAR  = (PARITY_MODE == 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;
  localparam logic [2:0] c_EXEC   = 3'd5;

  logic                r_rx_meta, r_rx_s, r_rx_prev;
  logic [1:0]          r_sync_vld;
  logic [2:0]          r_state, w_state_nxt;
  logic [c_DIV_W-1:0]  r_div;
  logic [c_OS_W-1:0]   r_os;
  logic [c_BIT_W-1:0]  r_bit;
  logic [c_PW-1:0]     r_shift;
  logic                r_par_bit, r_stop_bit;
  logic                r_reply_valid;
  logic [c_PW-1:0]     r_reply_data;
  logic                r_parity_error, r_frame_error, r_overrun;
  logic [DATA_W-1:0]   r_mem [c_DEPTH];

  logic                w_fall, w_tick, w_mid, w_end, w_exec;
  logic                w_rw, w_par_exp, w_par_err, w_frm_err, w_ok, w_load_ok;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data, w_rd_word;

  // r_rx_prev only goes high once rx_s carries a real line sample, so a line
  // held low across reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_rx_prev  <= 1'b0;
      r_sync_vld <= 2'b00;
    end else begin
      r_rx_meta  <= i_rx;
      r_rx_s     <= r_rx_meta;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      r_rx_prev  <= r_sync_vld[1] ? r_rx_s : 1'b0;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s;
  assign w_tick = (r_div == c_DIV_LAST);
  assign w_mid  = w_tick & (r_os == c_OS_MID);
  assign w_end  = w_tick & (r_os == c_OS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_os  <= '0;
    end else if (r_state == c_IDLE) begin
      r_div <= '0;
      r_os  <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      r_os  <= (r_os == c_OS_LAST) ? '0 : r_os + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit      <= '0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_stop_bit <= 1'b1;
    end else begin
      if (r_state == c_IDLE) begin
        r_bit <= '0;
      end else if (r_state == c_DATA && w_mid) begin
        r_shift <= {r_shift[c_PW-2:0], r_rx_s};
        r_bit   <= r_bit + 1'b1;
      end
      if (r_state == c_PARITY && w_mid) r_par_bit  <= r_rx_s;
      if (r_state == c_STOP   && w_mid) r_stop_bit <= r_rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_fall) w_state_nxt = c_START;
      c_START: begin
        if (w_mid && r_rx_s) w_state_nxt = c_IDLE;
        else if (w_end)      w_state_nxt = c_DATA;
      end
      c_DATA:   if (w_end && r_bit == c_BIT_LAST)
                  w_state_nxt = c_HAS_PAR ? c_PARITY : c_STOP;
      c_PARITY: if (w_end) w_state_nxt = c_STOP;
      c_STOP:   if (w_mid) w_state_nxt = c_EXEC;
      c_EXEC:   w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    o_busy  = (r_state != c_IDLE);
    o_state = r_state;
    w_exec  = (r_state == c_EXEC);
  end

  assign w_rw      = r_shift[c_PW-1];
  assign w_addr    = r_shift[c_PW-2 -: ADDR_W];
  assign w_data    = r_shift[DATA_W-1:0];
  assign w_par_exp = c_ODD_PAR ^ (^r_shift);
  assign w_par_err = c_HAS_PAR & (r_par_bit ^ w_par_exp);
  assign w_frm_err = ~r_stop_bit;
  assign w_ok      = w_exec & ~w_par_err & ~w_frm_err;
  assign w_load_ok = ~r_reply_valid | i_reply_ready;
  assign w_rd_word = w_rw ? r_mem[w_addr] : '0;

  // A dropped reply still lets a write land; only the reply word is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reply_valid  <= 1'b0;
      r_reply_data   <= '0;
      r_parity_error <= 1'b0;
      r_frame_error  <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_parity_error <= w_exec & w_par_err;
      r_frame_error  <= w_exec & w_frm_err;
      r_overrun      <= 1'b0;
      if (r_reply_valid && i_reply_ready) r_reply_valid <= 1'b0;
      if (w_ok) begin
        if (w_load_ok) begin
          r_reply_valid <= 1'b1;
          r_reply_data  <= {w_rw, w_addr, w_rd_word};
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_ok && !w_rw) begin
      r_mem[w_addr] <= w_data;
    end
  end

  assign o_reply_valid  = r_reply_valid;
  assign o_reply_data   = r_reply_data;
  assign o_parity_error = r_parity_error;
  assign o_frame_error  = r_frame_error;
  assign o_overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_regfile_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_regfile_rx : directed + randomized frames against a behavioural model
// Rev 1.0
// ============================================================================
module tb_uart_regfile_rx;

  localparam int c_B   = 4;
  localparam int c_OS  = 16;
  localparam int c_BIT = c_B * c_OS;
  localparam int c_MID = (c_OS / 2) * c_B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx0 = 1'b1, rdy0 = 1'b0, rx1 = 1'b1, rdy1 = 1'b0;
  logic        vld0, pe0, fe0, ov0, busy0;
  logic [7:0]  dat0;
  logic [2:0]  st0;
  logic        vld1, pe1, fe1, ov1, busy1;
  logic [12:0] dat1;
  logic [2:0]  st1;

  always #5 clk = ~clk;

  uart_regfile_rx #(.BAUD_DIV(c_B), .OVERSAMPLE(c_OS), .ADDR_W(3), .DATA_W(4), .PARITY_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_rx(rx0), .i_reply_ready(rdy0),
    .o_reply_valid(vld0), .o_reply_data(dat0), .o_parity_error(pe0),
    .o_frame_error(fe0), .o_overrun(ov0), .o_busy(busy0), .o_state(st0));

  uart_regfile_rx #(.BAUD_DIV(4), .OVERSAMPLE(c_OS), .ADDR_W(4), .DATA_W(8), .PARITY_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_rx(rx1), .i_reply_ready(rdy1),
    .o_reply_valid(vld1), .o_reply_data(dat1), .o_parity_error(pe1),
    .o_frame_error(fe1), .o_overrun(ov1), .o_busy(busy1), .o_state(st1));

  int total = 0;
  int bad   = 0;
  int n_pe[2], n_fe[2], n_ov[2];
  int n_busy0 = 0;
  int e_pe[2], e_fe[2], e_ov[2];
  bit          pend[2];
  logic [12:0] word[2];
  logic [7:0]  mm[2][16];

  always @(negedge clk) begin
    if (pe0) n_pe[0]++;
    if (fe0) n_fe[0]++;
    if (ov0) n_ov[0]++;
    if (pe1) n_pe[1]++;
    if (fe1) n_fe[1]++;
    if (ov1) n_ov[1]++;
    if (busy0) n_busy0++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic get_vld(input int w);
    return (w != 0) ? vld1 : vld0;
  endfunction

  function automatic logic [12:0] get_dat(input int w);
    return (w != 0) ? dat1 : {5'b0, dat0};
  endfunction

  task automatic set_rx(input int w, input logic b);
    if (w == 0) rx0 = b;
    else        rx1 = b;
  endtask

  task automatic hold_bit(input int w, input logic b);
    set_rx(w, b);
    repeat (c_BIT) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      pend[w] = 1'b0;
      word[w] = '0;
      for (int a = 0; a < 16; a++) mm[w][a] = 8'h00;
    end
  endtask

  // Drives one frame (start, payload MSB first, parity, stop) then one idle bit.
  task automatic send(input int w, input logic rw, input logic [3:0] addr, input logic [7:0] data,
                      input bit bad_par, input bit bad_stop, input bit chk_lat);
    int          pl;
    logic [12:0] pay;
    logic        par;
    pl  = (w != 0) ? 13 : 8;
    pay = (w != 0) ? {rw, addr, data} : {5'b0, rw, addr[2:0], data[3:0]};
    par = ^pay;
    if (w != 0) par = ~par;
    if (bad_par) par = ~par;
    hold_bit(w, 1'b0);
    for (int i = pl - 1; i >= 0; i--) hold_bit(w, pay[i]);
    hold_bit(w, par);
    set_rx(w, ~bad_stop);
    if (chk_lat) begin
      repeat (c_MID + 3) @(posedge clk);
      @(negedge clk);
      chk("lat_pre_valid", get_vld(w), 0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_post_valid", get_vld(w), 1);
      repeat (c_BIT - c_MID - 4) @(posedge clk);
      #1;
    end else begin
      repeat (c_BIT) @(posedge clk);
      #1;
    end
    hold_bit(w, 1'b1);
  endtask

  task automatic frame(input int w, input logic rw, input logic [3:0] addr, input logic [7:0] data,
                       input bit bad_par, input bit bad_stop, input bit chk_lat);
    logic [3:0]  a;
    logic [7:0]  d;
    logic [12:0] rep;
    send(w, rw, addr, data, bad_par, bad_stop, chk_lat);
    a = (w != 0) ? addr : {1'b0, addr[2:0]};
    d = (w != 0) ? data : {4'h0, data[3:0]};
    if (bad_par)  e_pe[w]++;
    if (bad_stop) e_fe[w]++;
    if (!bad_par && !bad_stop) begin
      if (w != 0) rep = {rw, a, (rw ? mm[w][a] : 8'h00)};
      else        rep = {5'b0, rw, a[2:0], (rw ? mm[w][a][3:0] : 4'h0)};
      if (!rw) mm[w][a] = d;
      if (pend[w]) e_ov[w]++;
      else begin
        pend[w] = 1'b1;
        word[w] = rep;
      end
    end
    chk("reply_valid", get_vld(w), pend[w]);
    if (pend[w]) chk("reply_data", get_dat(w), word[w]);
    chk("parity_err_count", n_pe[w], e_pe[w]);
    chk("frame_err_count", n_fe[w], e_fe[w]);
    chk("overrun_count", n_ov[w], e_ov[w]);
  endtask

  task automatic accept(input int w);
    @(posedge clk); #1;
    if (w == 0) rdy0 = 1'b1;
    else        rdy1 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    pend[w] = 1'b0;
    chk("valid_after_accept", get_vld(w), 0);
  endtask

  initial begin
    int b0;
    for (int w = 0; w < 2; w++) begin
      n_pe[w] = 0; n_fe[w] = 0; n_ov[w] = 0;
      e_pe[w] = 0; e_fe[w] = 0; e_ov[w] = 0;
    end
    model_reset();

    repeat (3) @(posedge clk); #1;
    chk("rst_valid", vld0, 0);
    chk("rst_data", dat0, 0);
    chk("rst_perr", pe0, 0);
    chk("rst_ferr", fe0, 0);
    chk("rst_ovr", ov0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_state", st0, 0);
    chk("rst_valid1", vld1, 0);
    chk("rst_data1", dat1, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk); #1;

    // write then read
    frame(0, 1'b0, 4'd2, 8'h5, 0, 0, 1);
    chk("wr_reply", dat0, 8'h20);
    accept(0);
    frame(0, 1'b1, 4'd2, 8'h0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      repeat (7) @(posedge clk); #1;
      chk("rd_hold_valid", vld0, 1);
      chk("rd_hold_data", dat0, 8'hA5);
    end
    accept(0);

    // parity error
    frame(0, 1'b0, 4'd3, 8'hF, 1, 0, 0);
    chk("perr_no_reply", vld0, 0);
    frame(0, 1'b1, 4'd3, 8'h0, 0, 0, 0);
    chk("rd_after_perr", dat0, 8'hB0);
    accept(0);

    // false start
    @(posedge clk); #1;
    rx0 = 1'b0;
    repeat (3 * c_B) @(posedge clk);
    @(negedge clk);
    chk("false_start_busy", busy0, 1);
    repeat (3 * c_B) @(posedge clk); #1;
    rx0 = 1'b1;
    repeat (c_BIT) @(posedge clk); #1;
    chk("false_start_idle", st0, 0);
    chk("false_start_valid", vld0, 0);
    chk("false_start_perr", n_pe[0], e_pe[0]);
    chk("false_start_ferr", n_fe[0], e_fe[0]);

    // framing error
    frame(0, 1'b0, 4'd4, 8'h7, 0, 1, 0);
    frame(0, 1'b1, 4'd4, 8'h0, 0, 0, 0);
    chk("rd_after_ferr", dat0, 8'hC0);
    accept(0);

    // back-pressure
    frame(0, 1'b1, 4'd2, 8'h0, 0, 0, 0);
    frame(0, 1'b0, 4'd1, 8'h3, 0, 0, 0);
    chk("overrun_keeps_data", dat0, 8'hA5);
    accept(0);
    frame(0, 1'b1, 4'd1, 8'h0, 0, 0, 0);
    chk("rd_after_overrun", dat0, 8'h93);
    accept(0);

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      logic       rw;
      logic [3:0] a;
      logic [7:0] d;
      bit         bp, bs;
      rw = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 7));
      d  = 8'($urandom_range(0, 15));
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 7) == 0);
      frame(0, rw, a, d, bp, bs, 0);
      if ($urandom_range(0, 1) == 1) accept(0);
    end

    // reset mid-frame, during address bit 1
    frame(0, 1'b1, 4'd2, 8'h0, 0, 0, 0);
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b0);
    rx0 = 1'b1;
    repeat (c_BIT / 2) @(posedge clk);
    #3;
    chk("pre_rst_state", st0, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", vld0, 0);
    chk("mid_rst_data", dat0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_state", st0, 0);
    chk("mid_rst_flags", {pe0, fe0, ov0}, 0);
    rx0 = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    b0 = n_busy0;
    repeat (3 * c_BIT) @(posedge clk); #1;
    chk("no_start_on_low_line", n_busy0 - b0, 0);
    rx0 = 1'b1;
    repeat (c_BIT) @(posedge clk); #1;
    frame(0, 1'b0, 4'd5, 8'h9, 0, 0, 0);
    accept(0);
    frame(0, 1'b1, 4'd5, 8'h0, 0, 0, 0);
    chk("post_rst_rd", dat0, 8'hD9);
    accept(0);
    frame(0, 1'b1, 4'd2, 8'h0, 0, 0, 0);
    chk("post_rst_mem_cleared", dat0, 8'hA0);
    accept(0);

    // alternate parameters, odd parity
    frame(1, 1'b0, 4'hA, 8'hC3, 0, 0, 0);
    accept(1);
    frame(1, 1'b1, 4'hA, 8'h00, 0, 0, 0);
    chk("alt_rd", dat1, 13'h1AC3);
    accept(1);
    for (int k = 0; k < 6; k++) begin
      logic       rw;
      logic [3:0] a;
      logic [7:0] d;
      bit         bp;
      rw = 1'($urandom_range(0, 1));
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 5) == 0);
      frame(1, rw, a, d, bp, 0, 0);
      if ($urandom_range(0, 1) == 1) accept(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_regfile_rx.md
# uart_regfile_rx

Parametrised UART receive-side command decoder with an integrated register file. It deserialises command frames of the form start, R/W, address, data, parity, stop, at widths set by parameters. It executes the read or write against an internal `2**ADDR_W x DATA_W` register file and presents the reply word to the UART transmitter over a valid/ready handshake. Compared with the fixed 3-bit-address/4-bit-data receiver, it adds:

- selectable parity mode
- false-start rejection
- stop-bit (framing) checking
- reply back-pressure with overrun reporting

## Interface
- `BAUD_DIV`, 104: system clocks per oversample tick (16 MHz / 9600 / 16).
- `OVERSAMPLE`, 16: ticks per bit; even, ≥4.
- `ADDR_W`, 3: address bits per frame; register file depth `2**ADDR_W`.
- `DATA_W`, 4: data bits per frame and register width.
- `PARITY_MODE`, 0: 0 = even, 1 = odd, 2 = none (no parity bit in frame).
- `clk` in 1: system clock; everything sampled on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: UART line, idle high, asynchronous to `clk`.
- `reply_valid` out 1: reply word available.
- `reply_ready` in 1: transmitter accepts reply.
- `reply_data` out `1+ADDR_W+DATA_W`: `{rw, addr, data}`; data = register value for read, zeros for write.
- `parity_error` out 1: one-cycle pulse, frame discarded on parity mismatch.
- `frame_error` out 1: one-cycle pulse, stop bit sampled low.
- `overrun` out 1: one-cycle pulse, reply dropped because the previous reply is still pending.
- `busy` out 1: high whenever state ≠ IDLE.
- `state` out 3: current FSM state code, for debug.

## Operation
- **Synchroniser.** `rx` passes through two flops, both resetting to 1. Every decision below uses the synchronised `rx_s`; the raw `rx` is never sampled.
- **Frame layout.** Fields in order, each field sent MSB first:
  - start (0)
  - rw (1 = read, 0 = write)
  - `ADDR_W` address bits
  - `DATA_W` data bits
  - parity, absent when `PARITY_MODE`=2
  - stop (1)
  - Payload P = `1+ADDR_W+DATA_W` bits.
- **Parity.**
  - Expected even parity = XOR of P; expected odd parity = its inverse.
  - Mismatch causes `parity_error`.
- **FSM states.**
  - IDLE=0: on a falling edge of `rx_s` (previous 1, current 0), go to START and clear the tick divider and tick counter.
  - START=1: sample the line at mid-bit. If `rx_s`=1 it was a false start: return to IDLE with no flags. Otherwise go to DATA at the end of the bit.
  - DATA=2: shift P bits into the shift register at mid-bit. After the last bit ends, go to PARITY, or to STOP when `PARITY_MODE`=2.
  - PARITY=3: sample the parity bit at mid-bit; go to STOP at the end of the bit.
  - STOP=4: sample at mid-bit, then go immediately to EXEC (the FSM does not wait for the end of the stop bit).
  - EXEC=5: one cycle, then IDLE.
- **EXEC action.**
  - If a parity or framing error occurred: pulse the corresponding flag; no register access and no reply. If both occurred, both flags pulse.
  - Otherwise, write: `mem[addr] <= data`.
  - Otherwise, read: the reply takes `mem[addr]`, which is the value before any same-cycle write.
- **Reply buffer.** Single entry.
  - Loaded in EXEC only when the buffer is empty, or when `reply_valid && reply_ready` in that same cycle.
  - Otherwise `overrun` pulses, the new reply is dropped, and `reply_data` keeps the old word. A write still executes.
  - `reply_valid` stays high and `reply_data` stays stable until a cycle with `reply_ready`=1.
- **Register file.** Built from flops; all entries reset to 0.

## Timing
- **Reset values:**
  - `reply_valid`, `parity_error`, `frame_error`, `overrun`, `busy`: 0
  - `reply_data`: 0
  - `state`: IDLE
  - synchroniser flops and `mem`: as stated above
- **Tick generation.** A tick fires when the divider reaches `BAUD_DIV-1`; the divider counts 0..`BAUD_DIV-1`.
- **Bit timing.**
  - The bit tick counter runs 0..`OVERSAMPLE-1`.
  - Mid-bit sample: on the tick where the counter equals `OVERSAMPLE/2-1`.
  - End of bit: on the tick where the counter equals `OVERSAMPLE-1`.
- **Latency.** Let T be the cycle of the stop-bit sample.
  - EXEC occurs at T+1.
  - `reply_valid`, the `mem` update and the error pulses all become visible at T+2.
- **Back-to-back frames.** A start edge arriving during EXEC is missed; one arriving from T+2 onward is detected. The input latency from `rx` to `rx_s` is 2 cycles.
- **Reply handshake.** A transfer occurs in a cycle with `reply_valid && reply_ready`. `reply_valid` falls on the next edge unless a new reply loads in that same cycle.
- **Reset mid-frame.** Asserting `rst` aborts the frame at once and drops any pending reply. After release, the block waits for a new falling edge; a line that is already low does not start a frame.

## Test plan
- **Write then read (defaults, even parity).**
  - Stimulus: write frame 0_010_0101, parity 1.
  - Required: `reply_data`=0x20 at T+2.
  - Stimulus: read frame 1_010_0000, parity 0.
  - Required: `reply_data`=0xA5; `reply_valid` held until `reply_ready`.
- **Parity error.**
  - Stimulus: write 0_011_1111, parity bit 1 (expected 0).
  - Required: `parity_error` single pulse; no `reply_valid`.
  - Required: a subsequent read of addr 3 replies 0xB0.
- **Line faults.**
  - Stimulus: `rx` low for 6 ticks, then high.
  - Required: false start; FSM returns to IDLE; no flags.
  - Stimulus: a valid frame with stop bit 0.
  - Required: `frame_error` pulse; no write.
- **Back-pressure.**
  - Stimulus: `reply_ready`=0; read addr 2 (0xA5 pending), then write 0_001_0011.
  - Required: `overrun` pulses; `reply_data` stays 0xA5.
  - Required: a later read of addr 1 returns 0x93.
- **Reset mid-frame.**
  - Stimulus: assert `rst` during the DATA bit carrying address bit 1.
  - Required: all outputs at reset values immediately.
  - Required: the next clean frame decodes correctly.
- **Alternate parameters.**
  - Configuration: `ADDR_W`=4, `DATA_W`=8, `PARITY_MODE`=1, `BAUD_DIV`=4.
  - Stimulus: write 0_1010_0xC3 with odd parity, then read addr 0xA.
  - Required: reply 13'h1AC3.
